// File: rtl/lm_sm_pkg.sv
// Shared definitions for the LM/SM sequencer and future multi-register instructions.
// State encodings are plain constants so legacy controllers can decode them directly.
package lm_sm_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned MASK_W = 8;
   localparam int unsigned IDX_W  = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Polarity of every T-register write strobe
   localparam logic T_WRITE_ACTIVE = 1'b0;

endpackage

// File: rtl/pri_enc_lsb.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit and a
// onehot vector for that bit, so the caller can clear it from the mask.
module pri_enc_lsb #(
   parameter int unsigned MASK_W = 8,
   parameter int unsigned IDX_W  = 3
) (
   input  logic [MASK_W-1:0] vec,
   output logic [IDX_W-1:0]  idx,
   output logic [MASK_W-1:0] onehot,
   output logic              found
);

   // Two's-complement trick isolates the lowest set bit
   assign onehot = vec & (~vec + MASK_W'(1));
   assign found  = |vec;

   // Scan from the top so the lowest set bit is written last and wins
   always_comb begin
      idx = '0;
      for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a register mask lowest-first, emitting one register/address
// step per clock, then hands the final address to the temp register.
module lm_sm_sequencer
   import lm_sm_pkg::*;
#(
   parameter int unsigned DATA_W = lm_sm_pkg::DATA_W,
   parameter int unsigned MASK_W = lm_sm_pkg::MASK_W,
   parameter int unsigned IDX_W  = lm_sm_pkg::IDX_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [MASK_W-1:0] mask,
   input  logic [DATA_W-1:0] base_addr,
   output logic              busy,
   output logic              step_valid,
   output logic [IDX_W-1:0]  reg_idx,
   output logic [DATA_W-1:0] mem_addr,
   output logic              rf_write,
   output logic              mem_write,
   output logic              done,
   output logic              t_write_n,
   output logic [DATA_W-1:0] t_data
);

   state_t            state_q, state_d;
   logic [MASK_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic              store_q, store_d;

   logic              busy_q, busy_d;
   logic              step_valid_q, step_valid_d;
   logic [IDX_W-1:0]  reg_idx_q, reg_idx_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic              rf_write_q, rf_write_d;
   logic              mem_write_q, mem_write_d;
   logic              done_q, done_d;
   logic              t_write_n_q, t_write_n_d;
   logic [DATA_W-1:0] t_data_q, t_data_d;

   logic [MASK_W-1:0] enc_vec;
   logic [MASK_W-1:0] enc_onehot;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_found;

   // In IDLE the first step is taken straight from the incoming mask so it is
   // registered on the start edge; afterwards the captured remainder drives it.
   assign enc_vec = (state_q == ST_IDLE) ? mask : rem_q;

   pri_enc_lsb #(
      .MASK_W (MASK_W),
      .IDX_W  (IDX_W)
   ) u_pri_enc (
      .vec    (enc_vec),
      .idx    (enc_idx),
      .onehot (enc_onehot),
      .found  (enc_found)
   );

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      addr_d       = addr_q;
      store_d      = store_q;
      busy_d       = busy_q;
      step_valid_d = 1'b0;
      rf_write_d   = 1'b0;
      mem_write_d  = 1'b0;
      done_d       = 1'b0;
      t_write_n_d  = ~T_WRITE_ACTIVE;
      reg_idx_d    = reg_idx_q;
      mem_addr_d   = mem_addr_q;
      t_data_d     = t_data_q;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               store_d = is_store;
               busy_d  = 1'b1;
               if (enc_found) begin
                  state_d      = ST_RUN;
                  step_valid_d = 1'b1;
                  rf_write_d   = ~is_store;
                  mem_write_d  = is_store;
                  reg_idx_d    = enc_idx;
                  mem_addr_d   = base_addr;
                  rem_d        = mask & ~enc_onehot;
                  addr_d       = base_addr + DATA_W'(1);
               end else begin
                  state_d     = ST_DONE;
                  done_d      = 1'b1;
                  t_write_n_d = T_WRITE_ACTIVE;
                  t_data_d    = base_addr;
                  rem_d       = '0;
                  addr_d      = base_addr;
               end
            end
         end

         ST_RUN: begin
            if (enc_found) begin
               step_valid_d = 1'b1;
               rf_write_d   = ~store_q;
               mem_write_d  = store_q;
               reg_idx_d    = enc_idx;
               mem_addr_d   = addr_q;
               rem_d        = rem_q & ~enc_onehot;
               addr_d       = addr_q + DATA_W'(1);
            end else begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               t_write_n_d = T_WRITE_ACTIVE;
               t_data_d    = addr_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rem_q        <= '0;
         addr_q       <= '0;
         store_q      <= 1'b0;
         busy_q       <= 1'b0;
         step_valid_q <= 1'b0;
         rf_write_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         done_q       <= 1'b0;
         t_write_n_q  <= ~T_WRITE_ACTIVE;
         reg_idx_q    <= '0;
         mem_addr_q   <= '0;
         t_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         addr_q       <= addr_d;
         store_q      <= store_d;
         busy_q       <= busy_d;
         step_valid_q <= step_valid_d;
         rf_write_q   <= rf_write_d;
         mem_write_q  <= mem_write_d;
         done_q       <= done_d;
         t_write_n_q  <= t_write_n_d;
         reg_idx_q    <= reg_idx_d;
         mem_addr_q   <= mem_addr_d;
         t_data_q     <= t_data_d;
      end
   end

   assign busy       = busy_q;
   assign step_valid = step_valid_q;
   assign reg_idx    = reg_idx_q;
   assign mem_addr   = mem_addr_q;
   assign rf_write   = rf_write_q;
   assign mem_write  = mem_write_q;
   assign done       = done_q;
   assign t_write_n  = t_write_n_q;
   assign t_data     = t_data_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: expected steps are queued from a mask/base
// model at start and popped as the DUT presents each step.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [7:0]  mask;
   logic [15:0] base_addr;
   logic        busy;
   logic        step_valid;
   logic [2:0]  reg_idx;
   logic [15:0] mem_addr;
   logic        rf_write;
   logic        mem_write;
   logic        done;
   logic        t_write_n;
   logic [15:0] t_data;

   typedef struct packed {
      logic [2:0]  idx;
      logic [15:0] addr;
      logic        store;
   } step_t;

   step_t       exp_q[$];
   logic [15:0] exp_tdata;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   lm_sm_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .mask       (mask),
      .base_addr  (base_addr),
      .busy       (busy),
      .step_valid (step_valid),
      .reg_idx    (reg_idx),
      .mem_addr   (mem_addr),
      .rf_write   (rf_write),
      .mem_write  (mem_write),
      .done       (done),
      .t_write_n  (t_write_n),
      .t_data     (t_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one transfer from the current IDLE cycle and scores it; returns in the
   // first IDLE cycle after done. noise_cyc>0 pulses start with junk operands then.
   task automatic run_xfer(input string name, input logic st, input logic [7:0] m,
                           input logic [15:0] b, input int noise_cyc);
      step_t       e;
      logic [15:0] a;
      int          n;
      int          cyc;
      bit          got_done;
      exp_q.delete();
      a = b;
      n = 0;
      got_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            e.idx = 3'(i);
            e.addr = a;
            e.store = st;
            exp_q.push_back(e);
            a = a + 16'd1;
            n++;
         end
      end
      exp_tdata = a;
      start = 1'b1;
      is_store = st;
      mask = m;
      base_addr = b;
      tick();
      start = 1'b0;
      mask = ~m;
      base_addr = ~b;
      is_store = ~st;
      cyc = 1;
      while (!got_done && cyc <= 20) begin
         start = (noise_cyc != 0 && cyc == noise_cyc) ? 1'b1 : 1'b0;
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy cyc %0d: got %b want 1", name, cyc, busy);
         end
         if (step_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s extra step cyc %0d: got idx %0d addr %h want none",
                        name, cyc, reg_idx, mem_addr);
            end else begin
               e = exp_q.pop_front();
               if ({reg_idx, mem_addr, rf_write, mem_write} !== {e.idx, e.addr, ~e.store, e.store}) begin
                  miscompares++;
                  $display("FAIL %s step cyc %0d: got idx %0d addr %h rf %b mw %b want idx %0d addr %h rf %b mw %b",
                           name, cyc, reg_idx, mem_addr, rf_write, mem_write,
                           e.idx, e.addr, ~e.store, e.store);
               end
            end
         end
         if (done === 1'b1) begin
            got_done = 1'b1;
            vectors++;
            if (t_data !== exp_tdata || t_write_n !== 1'b0 || step_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL %s done: got t_data %h t_write_n %b step %b want %h 0 0",
                        name, t_data, t_write_n, step_valid, exp_tdata);
            end
            vectors++;
            if (cyc != n + 1 || exp_q.size() != 0) begin
               miscompares++;
               $display("FAIL %s done timing: got cycle %0d with %0d steps left want cycle %0d with 0",
                        name, cyc, exp_q.size(), n + 1);
            end
         end else if (t_write_n !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s t_write_n cyc %0d: got %b want 1", name, cyc, t_write_n);
         end
         if (!got_done) begin
            tick();
            cyc++;
         end
      end
      start = 1'b0;
      if (!got_done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s timeout: got no done want done at cycle %0d", name, n + 1);
      end
      tick();
      vectors++;
      if ({busy, done, t_write_n, step_valid} !== 4'b0010) begin
         miscompares++;
         $display("FAIL %s post-done idle: got busy %b done %b twn %b step %b want 0 0 1 0",
                  name, busy, done, t_write_n, step_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      is_store = 1'b1;
      mask = 8'hFF;
      base_addr = 16'h1234;
      for (int c = 0; c < 2; c++) begin
         tick();
         vectors++;
         if ({busy, step_valid, rf_write, mem_write, done, t_write_n, reg_idx, mem_addr, t_data}
             !== {6'b000001, 3'd0, 16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset cyc %0d: got busy %b step %b rf %b mw %b done %b twn %b idx %0d addr %h td %h want all reset values",
                     c, busy, step_valid, rf_write, mem_write, done, t_write_n, reg_idx,
                     mem_addr, t_data);
         end
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0 || step_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset idle: got busy %b step %b want 0 0", busy, step_valid);
      end
   endtask

   task automatic test_lm();
      run_xfer("lm_a5", 1'b0, 8'hA5, 16'h0040, 0);
   endtask

   task automatic test_sm();
      run_xfer("sm_empty", 1'b1, 8'h00, 16'h0123, 0);
      run_xfer("sm_r7", 1'b1, 8'h80, 16'h0200, 0);
   endtask

   task automatic test_wrap();
      run_xfer("wrap_ff", 1'b0, 8'hFF, 16'hFFFE, 0);
   endtask

   task automatic test_back_to_back();
      run_xfer("run_noise", 1'b1, 8'h5A, 16'h3000, 2);
      run_xfer("after_done", 1'b0, 8'h03, 16'h4000, 0);
   endtask

   task automatic test_mid_reset();
      start = 1'b1;
      is_store = 1'b0;
      mask = 8'hFF;
      base_addr = 16'h1000;
      tick();
      start = 1'b0;
      tick();
      tick();
      vectors++;
      if (step_valid !== 1'b1 || reg_idx !== 3'd2 || mem_addr !== 16'h1002) begin
         miscompares++;
         $display("FAIL midreset step3: got step %b idx %0d addr %h want 1 2 1002",
                  step_valid, reg_idx, mem_addr);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if ({busy, step_valid, done, t_write_n, reg_idx, mem_addr, t_data}
          !== {4'b0001, 3'd0, 16'h0000, 16'h0000}) begin
         miscompares++;
         $display("FAIL midreset idle: got busy %b step %b done %b twn %b idx %0d addr %h td %h want reset values",
                  busy, step_valid, done, t_write_n, reg_idx, mem_addr, t_data);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || t_write_n !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset no_done: got done %b twn %b busy %b want 0 1 0",
                  done, t_write_n, busy);
      end
      run_xfer("after_reset", 1'b1, 8'h11, 16'h0800, 0);
   endtask

   initial begin
      test_reset();
      test_lm();
      test_sm();
      test_wrap();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
